// File: rtl/vsd_pkg.sv
// Shared constants and helpers for the virtual-SD SPI router.
// Slot vectors are at most 8 wide, so the priority helper works on a fixed 8-bit vector.
package vsd_pkg;

    localparam int DEF_ACT_TIMEOUT      = 1_000_000;
    localparam int DEF_MOUNT_RST_CYCLES = 10_000_000;
    localparam int MAX_VSD              = 8;

    typedef struct packed {
        logic       valid;
        logic [2:0] idx;
    } lowest_t;

    // Keeps sel_idx at least one bit wide when there is a single slot.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic lowest_t lowest_set(input logic [MAX_VSD-1:0] vec);
        lowest_t r;
        r = '0;
        for (int i = MAX_VSD - 1; i >= 0; i--) begin
            if (vec[i]) begin
                r.valid = 1'b1;
                r.idx   = 3'(i);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/vsd_spi_router_if.sv
// SPI bundle between the core master, the virtual slots and the physical card.
// slave is the router's view; master is the view of everything around it.
interface vsd_spi_router_if #(
    parameter int NUM_VSD = 2
);
    logic               core_sck;
    logic               core_mosi;
    logic               core_cs_n;
    logic               core_miso;
    logic [NUM_VSD-1:0] vsd_cs_n;
    logic [NUM_VSD-1:0] vsd_miso;
    logic               sd_sck;
    logic               sd_mosi;
    logic               sd_cs_n;
    logic               sd_miso;

    modport master (
        output core_sck, core_mosi, core_cs_n, vsd_miso, sd_miso,
        input  core_miso, vsd_cs_n, sd_sck, sd_mosi, sd_cs_n
    );

    modport slave (
        input  core_sck, core_mosi, core_cs_n, vsd_miso, sd_miso,
        output core_miso, vsd_cs_n, sd_sck, sd_mosi, sd_cs_n
    );
endinterface

// File: rtl/vsd_spi_router_act_timer.sv
// Retriggerable saturating counter: trigger clears it, it then counts up to LEN and stops.
// busy stays high until LEN cycles have passed since the last trigger; reset leaves it idle.
module act_timer #(
    parameter int LEN = 8
) (
    input  logic clk,
    input  logic reset_n,
    input  logic trigger,
    output logic busy
);
    localparam int            CW  = $clog2(LEN + 1);
    localparam logic [CW-1:0] MAX = CW'(LEN);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= MAX;
        end else if (trigger) begin
            cnt <= '0;
        end else if (cnt != MAX) begin
            cnt <= cnt + CW'(1);
        end
    end

    assign busy = (cnt != MAX);

endmodule

// File: rtl/vsd_spi_router.sv
// Routes the core SPI master to one of NUM_VSD virtual SD slots or the physical card,
// with activity LEDs and a cold-reset request after every image mount.
module vsd_spi_router
    import vsd_pkg::*;
#(
    parameter  int NUM_VSD          = 2,
    parameter  int ACT_TIMEOUT      = DEF_ACT_TIMEOUT,
    parameter  int MOUNT_RST_CYCLES = DEF_MOUNT_RST_CYCLES,
    localparam int IDX_W            = idx_w(NUM_VSD)
) (
    input  logic               clk_sys,
    input  logic               reset_n,
    input  logic [NUM_VSD-1:0] img_mounted,
    input  logic [NUM_VSD-1:0] img_present,
    vsd_spi_router_if.slave    spi,
    output logic               sel_vsd,
    output logic [IDX_W-1:0]   sel_idx,
    output logic               act_vsd,
    output logic               act_phys,
    output logic               reset_req
);

    logic [NUM_VSD-1:0] mounted;
    lowest_t            pending;
    logic               sel_miso;
    logic               mosi_q;
    logic               miso_q;
    logic               toggle;
    logic               act;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            mounted <= '0;
        end else begin
            mounted <= (mounted & ~img_mounted) | (img_present & img_mounted);
        end
    end

    assign pending = lowest_set(MAX_VSD'(mounted));

    // The target only changes while chip select is high, so a transfer never sees a switch.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            sel_vsd <= 1'b0;
            sel_idx <= '0;
        end else if (spi.core_cs_n) begin
            sel_vsd <= pending.valid;
            sel_idx <= pending.valid ? IDX_W'(pending.idx) : '0;
        end
    end

    always_comb begin
        spi.vsd_cs_n = '1;
        for (int i = 0; i < NUM_VSD; i++) begin
            if (sel_vsd && (sel_idx == IDX_W'(i))) begin
                spi.vsd_cs_n[i] = spi.core_cs_n;
            end
        end
    end

    assign spi.sd_cs_n   = sel_vsd | spi.core_cs_n;
    assign spi.sd_sck    = spi.core_sck  & ~spi.sd_cs_n;
    assign spi.sd_mosi   = spi.core_mosi & ~spi.sd_cs_n;
    assign sel_miso      = sel_vsd ? spi.vsd_miso[sel_idx] : spi.sd_miso;
    assign spi.core_miso = spi.core_cs_n | sel_miso;

    // Reset values match the idle bus (MOSI low, MISO pulled high) so leaving reset is quiet.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            mosi_q <= 1'b0;
            miso_q <= 1'b1;
        end else begin
            mosi_q <= spi.core_mosi;
            miso_q <= spi.core_miso;
        end
    end

    assign toggle = (spi.core_mosi ^ mosi_q) | (spi.core_miso ^ miso_q);

    act_timer #(.LEN(ACT_TIMEOUT)) u_act (
        .clk     (clk_sys),
        .reset_n (reset_n),
        .trigger (toggle),
        .busy    (act)
    );

    act_timer #(.LEN(MOUNT_RST_CYCLES)) u_mount_rst (
        .clk     (clk_sys),
        .reset_n (reset_n),
        .trigger (|img_mounted),
        .busy    (reset_req)
    );

    assign act_vsd  = act & sel_vsd;
    assign act_phys = act & ~sel_vsd;

endmodule

// File: tb/tb_vsd_spi_router.sv
// Randomized bench for vsd_spi_router against a cycle-level behavioural model,
// with directed scenarios pinned by literal expectations.
module tb_vsd_spi_router;

    localparam int NUM_VSD = 2;
    localparam int ACT     = 8;
    localparam int MRST    = 16;

    logic       clk_sys     = 1'b0;
    logic       reset_n     = 1'b0;
    logic [1:0] img_mounted = '0;
    logic [1:0] img_present = '0;
    logic       sel_vsd;
    logic       sel_idx;
    logic       act_vsd;
    logic       act_phys;
    logic       reset_req;
    bit         check_en    = 1'b0;
    int         n_checks    = 0;
    int         n_pass      = 0;

    vsd_spi_router_if #(.NUM_VSD(NUM_VSD)) spi ();

    vsd_spi_router #(
        .NUM_VSD          (NUM_VSD),
        .ACT_TIMEOUT      (ACT),
        .MOUNT_RST_CYCLES (MRST)
    ) dut (
        .clk_sys     (clk_sys),
        .reset_n     (reset_n),
        .img_mounted (img_mounted),
        .img_present (img_present),
        .spi         (spi),
        .sel_vsd     (sel_vsd),
        .sel_idx     (sel_idx),
        .act_vsd     (act_vsd),
        .act_phys    (act_phys),
        .reset_req   (reset_req)
    );

    always #5 clk_sys = ~clk_sys;

    // Model state: mount flags, committed target, cycles since last bus toggle, reset cycles left.
    bit m_mounted [NUM_VSD];
    bit m_sel_vsd;
    int m_sel_idx;
    int m_age;
    int m_rst_left;
    bit m_prev_mosi;
    bit m_prev_miso;

    task automatic model_reset();
        foreach (m_mounted[i]) m_mounted[i] = 1'b0;
        m_sel_vsd   = 1'b0;
        m_sel_idx   = 0;
        m_age       = ACT;
        m_rst_left  = 0;
        m_prev_mosi = 1'b0;
        m_prev_miso = 1'b1;
    endtask

    function automatic bit exp_miso();
        if (spi.core_cs_n) return 1'b1;
        return m_sel_vsd ? spi.vsd_miso[m_sel_idx] : spi.sd_miso;
    endfunction

    initial begin
        model_reset();
        forever begin
            @(posedge clk_sys or negedge reset_n);
            if (!reset_n) begin
                model_reset();
            end else begin
                bit miso_now;
                bit tog;
                int first;
                miso_now    = exp_miso();
                tog         = (spi.core_mosi != m_prev_mosi) || (miso_now != m_prev_miso);
                m_prev_mosi = spi.core_mosi;
                m_prev_miso = miso_now;
                m_age       = tog ? 0 : ((m_age < ACT) ? m_age + 1 : ACT);
                if (img_mounted != 2'b00)  m_rst_left = MRST;
                else if (m_rst_left > 0)   m_rst_left = m_rst_left - 1;
                if (spi.core_cs_n) begin
                    first = -1;
                    for (int i = NUM_VSD - 1; i >= 0; i--) if (m_mounted[i]) first = i;
                    m_sel_vsd = (first >= 0);
                    m_sel_idx = (first >= 0) ? first : 0;
                end
                for (int i = 0; i < NUM_VSD; i++) if (img_mounted[i]) m_mounted[i] = img_present[i];
            end
        end
    end

    task automatic check(input string name, input int actual, input int expected);
        n_checks++;
        if (actual == expected) n_pass++;
        else $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    endtask

    task automatic check_output();
        logic [1:0] e_vcs;
        bit         e_sdcs;
        bit         e_act;
        for (int i = 0; i < NUM_VSD; i++)
            e_vcs[i] = (m_sel_vsd && m_sel_idx == i) ? spi.core_cs_n : 1'b1;
        e_sdcs = m_sel_vsd | spi.core_cs_n;
        e_act  = (m_age < ACT);
        check("vsd_cs_n",  int'(spi.vsd_cs_n),  int'(e_vcs));
        check("sd_cs_n",   int'(spi.sd_cs_n),   int'(e_sdcs));
        check("sd_sck",    int'(spi.sd_sck),    int'(spi.core_sck & ~e_sdcs));
        check("sd_mosi",   int'(spi.sd_mosi),   int'(spi.core_mosi & ~e_sdcs));
        check("core_miso", int'(spi.core_miso), int'(exp_miso()));
        check("sel_vsd",   int'(sel_vsd),       int'(m_sel_vsd));
        check("sel_idx",   int'(sel_idx),       m_sel_idx);
        check("act_vsd",   int'(act_vsd),       int'(e_act & m_sel_vsd));
        check("act_phys",  int'(act_phys),      int'(e_act & ~m_sel_vsd));
        check("reset_req", int'(reset_req),     int'(m_rst_left > 0));
    endtask

    initial begin
        forever begin
            @(negedge clk_sys);
            #3;
            if (check_en) check_output();
        end
    end

    task automatic apply_stimulus(input logic cs_n, input logic sck, input logic mosi,
                                  input logic [1:0] vmiso, input logic smiso,
                                  input logic [1:0] mnt, input logic [1:0] pres);
        @(negedge clk_sys);
        #1;
        spi.core_cs_n = cs_n;
        spi.core_sck  = sck;
        spi.core_mosi = mosi;
        spi.vsd_miso  = vmiso;
        spi.sd_miso   = smiso;
        img_mounted   = mnt;
        img_present   = pres;
    endtask

    task automatic idle(input logic cs_n);
        apply_stimulus(cs_n, 1'b0, spi.core_mosi, spi.vsd_miso, spi.sd_miso, 2'b00, 2'b00);
    endtask

    task automatic strobe(input logic cs_n, input logic [1:0] mnt, input logic [1:0] pres);
        apply_stimulus(cs_n, 1'b0, spi.core_mosi, spi.vsd_miso, spi.sd_miso, mnt, pres);
    endtask

    initial begin
        int cnt;
        int cnt_v;
        logic cs;
        spi.core_cs_n = 1'b1;
        spi.core_sck  = 1'b0;
        spi.core_mosi = 1'b0;
        spi.vsd_miso  = 2'b11;
        spi.sd_miso   = 1'b1;

        repeat (3) @(negedge clk_sys);
        #1 reset_n = 1'b1;
        check_en = 1'b1;
        #3;
        check("reset sel_vsd",   int'(sel_vsd),   0);
        check("reset sel_idx",   int'(sel_idx),   0);
        check("reset act_phys",  int'(act_phys),  0);
        check("reset reset_req", int'(reset_req), 0);

        $display("[TB] scenario 1: physical card activity");
        for (int k = 0; k < 4; k++)
            apply_stimulus(1'b0, 1'b1, ~spi.core_mosi, 2'b11, 1'b1, 2'b00, 2'b00);
        #3;
        check("phys sd_cs_n",  int'(spi.sd_cs_n),  0);
        check("phys vsd_cs_n", int'(spi.vsd_cs_n), 3);
        cnt = 0; cnt_v = 0;
        for (int k = 0; k < 12; k++) begin
            idle(1'b0);
            #3;
            cnt   += int'(act_phys);
            cnt_v += int'(act_vsd);
        end
        check("act_phys cycles", cnt, 8);
        check("act_vsd cycles",  cnt_v, 0);
        idle(1'b1);

        $display("[TB] scenario 2: mount slot 1 while idle");
        strobe(1'b1, 2'b10, 2'b10);
        cnt = 0;
        for (int k = 0; k < 20; k++) begin
            idle(1'b1);
            #3;
            if (k == 0) check("sel_vsd before commit", int'(sel_vsd), 0);
            if (k == 1) begin
                check("sel_vsd after commit", int'(sel_vsd), 1);
                check("sel_idx after commit", int'(sel_idx), 1);
            end
            cnt += int'(reset_req);
        end
        check("reset_req length", cnt, 16);

        $display("[TB] scenario 3: mount slot 0 during a transfer");
        apply_stimulus(1'b0, 1'b0, spi.core_mosi, 2'b11, 1'b1, 2'b00, 2'b00);
        strobe(1'b0, 2'b01, 2'b01);
        repeat (5) idle(1'b0);
        #3;
        check("sel_idx held in transfer", int'(sel_idx), 1);
        check("vsd_cs_n in transfer",     int'(spi.vsd_cs_n), 1);
        idle(1'b1);
        #3;
        check("sel_idx first idle cycle", int'(sel_idx), 1);
        idle(1'b1);
        #3;
        check("sel_idx after switch",   int'(sel_idx), 0);
        check("vsd_cs_n after switch",  int'(spi.vsd_cs_n), 3);

        $display("[TB] scenario 4: back-to-back mount strobes");
        repeat (20) idle(1'b1);
        #3;
        check("reset_req expired", int'(reset_req), 0);
        strobe(1'b1, 2'b01, 2'b01);
        cnt = 0;
        for (int k = 1; k <= 40; k++) begin
            if (k == 10) strobe(1'b1, 2'b10, 2'b10);
            else         idle(1'b1);
            #3;
            cnt += int'(reset_req);
        end
        check("reset_req extended length", cnt, 26);
        check("both mounted sel_vsd", int'(sel_vsd), 1);
        check("both mounted sel_idx", int'(sel_idx), 0);

        $display("[TB] scenario 5: unmount back to physical");
        strobe(1'b1, 2'b10, 2'b00);
        idle(1'b1);
        strobe(1'b1, 2'b01, 2'b00);
        idle(1'b1);
        idle(1'b1);
        #3;
        check("unmount sel_vsd", int'(sel_vsd), 0);
        apply_stimulus(1'b0, 1'b0, spi.core_mosi, 2'b11, 1'b0, 2'b00, 2'b00);
        #3;
        check("miso from sd low", int'(spi.core_miso), 0);
        apply_stimulus(1'b0, 1'b0, spi.core_mosi, 2'b00, 1'b1, 2'b00, 2'b00);
        #3;
        check("miso from sd high", int'(spi.core_miso), 1);

        $display("[TB] scenario 6: reset during a transfer");
        strobe(1'b1, 2'b01, 2'b01);
        idle(1'b1);
        idle(1'b1);
        apply_stimulus(1'b0, 1'b0, spi.core_mosi, 2'b00, 1'b1, 2'b00, 2'b00);
        idle(1'b0);
        #3;
        check("act_vsd before reset", int'(act_vsd), 1);
        @(negedge clk_sys);
        #2 reset_n = 1'b0;
        #2;
        check("async reset sel_vsd",   int'(sel_vsd),     0);
        check("async reset reset_req", int'(reset_req),   0);
        check("async reset act_vsd",   int'(act_vsd),     0);
        check("async reset act_phys",  int'(act_phys),    0);
        check("async reset sd_cs_n",   int'(spi.sd_cs_n), 0);
        repeat (2) @(negedge clk_sys);
        #1 reset_n = 1'b1;

        $display("[TB] random phase");
        for (int k = 0; k < 1500; k++) begin
            logic [1:0] mnt;
            cs  = spi.core_cs_n;
            if ($urandom_range(7) == 0) cs = ~cs;
            mnt = ($urandom_range(15) == 0) ? 2'($urandom) : 2'b00;
            apply_stimulus(cs, 1'($urandom),
                           ($urandom_range(5) == 0) ? ~spi.core_mosi : spi.core_mosi,
                           ($urandom_range(5) == 0) ? 2'($urandom) : spi.vsd_miso,
                           ($urandom_range(5) == 0) ? ~spi.sd_miso : spi.sd_miso,
                           mnt, 2'($urandom));
            if (k == 700) begin
                @(negedge clk_sys);
                #2 reset_n = 1'b0;
                repeat (2) @(negedge clk_sys);
                #1 reset_n = 1'b1;
            end
        end

        idle(1'b1);
        #3;
        check_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
